hs_npu_gatekeeper_ctrl: RTL and testbench
=========================================

Name: hs_npu_gatekeeper_ctrl

Overview:
- Job sequencer for the NPU input-FIFO -> gatekeeper chain -> output-FIFO path.
- Accepts a job request (beat count) and waits until the input FIFO holds enough data and the output FIFO has enough space. It then fires a single start pulse into the first gatekeeper with the beat count.
- Tracks the skewed activity wavefront through STAGES chained gatekeepers and signals done when the last stage finishes. Supports synchronous abort with a FIFO flush pulse.

Parameters:
STAGES, 4, number of chained gatekeeper stages (>=1)
DEPTH, 4, depth of both FIFOs; max legal beat count
CNT_W, 32, width of beat count (matches uword)
LVL_W, $clog2(DEPTH+1), width of FIFO level/space inputs

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  job request valid
req_ready  out  1  job request ready
req_cycles  in  CNT_W  beats to process for this job
abort  in  1  cancel current job
in_fifo_level  in  LVL_W  entries currently in input FIFO
out_fifo_space  in  LVL_W  free entries in output FIFO
gk_start  out  1  start pulse to first gatekeeper
gk_enable_cycles  out  CNT_W  beat count to gatekeepers
stage_active  out  STAGES  expected active window per stage
fifo_flush  out  1  flush pulse to both FIFOs
busy  out  1  job in progress
done  out  1  job complete pulse
err  out  1  illegal request pulse

Behaviour:
- Reset: clk, rst_n sampled only on posedge clk (synchronous active-low). While rst_n=0 at an edge: state=IDLE and all registered outputs 0 (gk_start, gk_enable_cycles, stage_active, fifo_flush, done, err, busy). req_ready is 0 during reset; it is 1 from the first cycle in IDLE after release.
- Reset mid-job: immediate return to IDLE. No done, no flush.
- States: IDLE, WAIT_RES, START, RUN, DONE.
- IDLE:
  - req_ready = !abort.
  - Handshake on req_valid&&req_ready.
  - If req_cycles > DEPTH: err=1 next cycle (1-cycle pulse), stay IDLE.
  - If req_cycles == 0: go to DONE (no start).
  - Otherwise: latch cycles into gk_enable_cycles, go to WAIT_RES.
  - req_ready=0 in all other states.
- WAIT_RES: go to START when in_fifo_level >= cycles AND out_fifo_space >= cycles (same-cycle compare, both zero-extended to CNT_W). Otherwise hold.
- START:
  - gk_start=1 for exactly this cycle (cycle T).
  - Load counter = cycles+STAGES-1.
  - Go to RUN.
- RUN:
  - stage_active is a shift register. Bit0 is fed 1 for beats 0..cycles-1 after T, then 0; each cycle it shifts toward bit STAGES-1.
  - Result: stage_active[k]=1 during cycles T+1+k .. T+k+cycles.
  - Counter decrements each cycle. At counter==1 go to DONE, i.e. the last RUN cycle is T+cycles+STAGES-1.
- DONE: done=1 for one cycle, stage_active=0, then IDLE.
- busy=1 in WAIT_RES, START, RUN, DONE.
- gk_enable_cycles holds the latched value until the next accepted job.
- Abort:
  - In any non-IDLE state: next state IDLE, fifo_flush=1 for one cycle, stage_active cleared, no done pulse.
  - Abort in IDLE: no request accepted (req_ready=0), no flush.
  - Abort coinciding with the START cycle: gk_start still asserted that cycle; flush follows next cycle.
- Counter arithmetic uses CNT_W+1 bits internally; no wrap is possible since cycles <= DEPTH.
- One outstanding job only. A new request can be accepted the cycle after DONE.

Test Plan:
- Reset: hold rst_n=0 3 cycles with req_valid=1 -> all outputs 0, no handshake. After release, req_ready=1 in the first IDLE cycle.
- Nominal: STAGES=4, DEPTH=4, req_cycles=3, levels already 4/4 -> gk_start at T (accept+2). stage_active[0] high T+1..T+3, stage_active[3] high T+4..T+6. done at T+7. gk_enable_cycles=3 throughout.
- Resource wait: req_cycles=4, in_fifo_level=2 for 5 cycles then 4; out_fifo_space=4 -> stay WAIT_RES, no gk_start until the cycle after level reaches 4.
- Illegal and zero: req_cycles=5 -> err pulse, busy never 1. req_cycles=0 -> done pulse 1 cycle after accept, gk_start never asserted.
- Abort: assert abort in second RUN cycle -> fifo_flush pulse next cycle, stage_active=0, state IDLE, no done, req_ready=1 again.
- Back-to-back: second req_valid held through first job -> accepted in the cycle after done; abort+req_valid in IDLE -> not accepted.

Source files
------------

// File: rtl/hs_npu_gatekeeper_ctrl_if.sv
// Handshake/status bundle between the job source and the gatekeeper sequencer.
interface hs_npu_gatekeeper_ctrl_if #(
   parameter int STAGES = 4,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 32,
   parameter int LVL_W  = $clog2(DEPTH + 1)
);
   logic              req_valid;
   logic              req_ready;
   logic [CNT_W-1:0]  req_cycles;
   logic              abort;
   logic [LVL_W-1:0]  in_fifo_level;
   logic [LVL_W-1:0]  out_fifo_space;
   logic              gk_start;
   logic [CNT_W-1:0]  gk_enable_cycles;
   logic [STAGES-1:0] stage_active;
   logic              fifo_flush;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      output req_valid, req_cycles, abort, in_fifo_level, out_fifo_space,
      input  req_ready, gk_start, gk_enable_cycles, stage_active,
             fifo_flush, busy, done, err
   );

   modport slave (
      input  req_valid, req_cycles, abort, in_fifo_level, out_fifo_space,
      output req_ready, gk_start, gk_enable_cycles, stage_active,
             fifo_flush, busy, done, err
   );
endinterface

// File: rtl/hs_npu_gatekeeper_ctrl.sv
// Job sequencer: waits for FIFO resources, fires the first gatekeeper and
// tracks the skewed activity wavefront through STAGES chained gatekeepers.
//
// state    | meaning
// IDLE     | ready for a job request
// WAIT_RES | job latched, waiting for input data and output space
// START    | gk_start pulse cycle
// RUN      | wavefront travelling through the gatekeeper chain
// DONE     | done pulse, back to IDLE next cycle
module hs_npu_gatekeeper_ctrl #(
   parameter int STAGES = 4,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 32,
   parameter int LVL_W  = $clog2(DEPTH + 1)
) (
   input logic                    clk,
   input logic                    rst_n,
   hs_npu_gatekeeper_ctrl_if.slave bus
);
   typedef enum logic [2:0] {IDLE, WAIT_RES, START, RUN, DONE} state_t;

   state_t            state, state_nxt;
   logic [CNT_W:0]    cnt, cnt_nxt;
   logic [CNT_W-1:0]  feed_left, feed_left_nxt;
   logic [CNT_W-1:0]  cycles_nxt;
   logic [STAGES-1:0] sa_nxt;
   logic              start_nxt, flush_nxt, done_nxt, err_nxt, busy_nxt;
   logic              accept, illegal, res_ok;
   logic [LVL_W-1:0]  lvl_in, spc_out;

   assign lvl_in        = bus.in_fifo_level;
   assign spc_out       = bus.out_fifo_space;
   assign bus.req_ready = rst_n && (state == IDLE) && !bus.abort;
   assign accept        = bus.req_valid && bus.req_ready;
   assign illegal       = bus.req_cycles > CNT_W'(DEPTH);
   assign res_ok        = (CNT_W'(lvl_in) >= bus.gk_enable_cycles) &&
                          (CNT_W'(spc_out) >= bus.gk_enable_cycles);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state                <= IDLE;
         cnt                  <= '0;
         feed_left            <= '0;
         bus.gk_start         <= 1'b0;
         bus.gk_enable_cycles <= '0;
         bus.stage_active     <= '0;
         bus.fifo_flush       <= 1'b0;
         bus.done             <= 1'b0;
         bus.err              <= 1'b0;
         bus.busy             <= 1'b0;
      end else begin
         state                <= state_nxt;
         cnt                  <= cnt_nxt;
         feed_left            <= feed_left_nxt;
         bus.gk_start         <= start_nxt;
         bus.gk_enable_cycles <= cycles_nxt;
         bus.stage_active     <= sa_nxt;
         bus.fifo_flush       <= flush_nxt;
         bus.done             <= done_nxt;
         bus.err              <= err_nxt;
         bus.busy             <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (accept && !illegal)
                      state_nxt = (bus.req_cycles == '0) ? DONE : WAIT_RES;
         WAIT_RES: if (res_ok) state_nxt = START;
         START:    state_nxt = RUN;
         RUN:      if (cnt == (CNT_W+1)'(1)) state_nxt = DONE;
         DONE:     state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
      if (bus.abort && state != IDLE) state_nxt = IDLE;
   end

   // Outputs are registered, so they are computed from the upcoming state.
   always_comb begin
      start_nxt     = (state_nxt == START);
      done_nxt      = (state_nxt == DONE);
      busy_nxt      = (state_nxt != IDLE);
      flush_nxt     = bus.abort && (state != IDLE);
      err_nxt       = accept && illegal;
      cycles_nxt    = bus.gk_enable_cycles;
      cnt_nxt       = cnt;
      feed_left_nxt = feed_left;
      sa_nxt        = '0;
      if (accept && !illegal && bus.req_cycles != '0)
         cycles_nxt = bus.req_cycles;
      if (state_nxt == RUN) begin
         sa_nxt = bus.stage_active << 1;
         if (state == START) begin
            sa_nxt[0]     = 1'b1;
            feed_left_nxt = bus.gk_enable_cycles - CNT_W'(1);
            cnt_nxt       = {1'b0, bus.gk_enable_cycles} + (CNT_W+1)'(STAGES - 1);
         end else begin
            sa_nxt[0] = (feed_left != '0);
            if (feed_left != '0) feed_left_nxt = feed_left - CNT_W'(1);
            cnt_nxt = cnt - (CNT_W+1)'(1);
         end
      end
   end
endmodule

// File: tb/tb_hs_npu_gatekeeper_ctrl.sv
// Directed bench: stimulus queues expected output events, a monitor pops and compares them.
module tb_hs_npu_gatekeeper_ctrl;
   localparam int S = 4;

   localparam int K_START = 0;
   localparam int K_SA    = 1;
   localparam int K_FLUSH = 2;
   localparam int K_DONE  = 3;
   localparam int K_ERR   = 4;

   typedef struct {
      int          kind;
      int          cyc;
      logic [31:0] data;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;
   logic [S-1:0] prev_sa = '0;
   ev_t  q[$];

   hs_npu_gatekeeper_ctrl_if #(.STAGES(S), .DEPTH(4), .CNT_W(32)) bus ();

   hs_npu_gatekeeper_ctrl #(.STAGES(S), .DEPTH(4), .CNT_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic push(int k, int c, logic [31:0] d);
      ev_t e;
      e.kind = k; e.cyc = c; e.data = d;
      q.push_back(e);
   endtask

   // Expected events of a full job starting at cycle t: stage k active t+1+k .. t+k+c.
   task automatic exp_job(int t, int c);
      logic [S-1:0] a, p;
      push(K_START, t, c);
      p = '0;
      for (int cy = t + 1; cy <= t + c + S; cy++) begin
         for (int k = 0; k < S; k++) a[k] = (cy >= t + 1 + k) && (cy <= t + k + c);
         if (a != p) push(K_SA, cy, 32'(a));
         p = a;
      end
      push(K_DONE, t + c + S, 0);
   endtask

   task automatic got(int k, logic [31:0] d);
      ev_t e;
      checks++;
      if (q.size() == 0) begin
         errors++;
         $display("FAIL event: unexpected kind %0d data %0h @cyc %0d, expected none", k, d, cyc);
      end else begin
         e = q.pop_front();
         if (e.kind != k || e.cyc != cyc || e.data !== d) begin
            errors++;
            $display("FAIL event: got kind %0d data %0h @cyc %0d, expected kind %0d data %0h @cyc %0d",
                     k, d, cyc, e.kind, e.data, e.cyc);
         end
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.gk_start === 1'b1) got(K_START, bus.gk_enable_cycles);
         if (bus.stage_active !== prev_sa) begin
            got(K_SA, 32'(bus.stage_active));
            prev_sa = bus.stage_active;
         end
         if (bus.fifo_flush === 1'b1) got(K_FLUSH, 0);
         if (bus.done === 1'b1) got(K_DONE, 0);
         if (bus.err === 1'b1) got(K_ERR, 0);
         if (q.size() > 0 && q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL event: missing kind %0d data %0h, expected @cyc %0d, now %0d",
                     q[0].kind, q[0].data, q[0].cyc, cyc);
            void'(q.pop_front());
         end
      end
   end

   task automatic step(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int a;

   initial begin
      rst_n = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_cycles = 3;
      bus.abort = 1'b0;
      bus.in_fifo_level = 4;
      bus.out_fifo_space = 4;

      // reset held 3 cycles with a pending request
      step(1);
      for (int i = 0; i < 3; i++) begin
         check("rst_outs", {bus.gk_start, bus.fifo_flush, bus.done, bus.err, bus.busy,
                            bus.stage_active, bus.gk_enable_cycles}, 64'd0);
         check("rst_ready", bus.req_ready, 1'b0);
         if (i < 2) step(1);
      end
      bus.req_valid = 1'b0;
      rst_n = 1'b1;
      #1;
      check("ready_after_rst", bus.req_ready, 1'b1);
      mon_en = 1'b1;

      // nominal job, 3 beats
      step(1);
      a = cyc;
      bus.req_valid = 1'b1;
      bus.req_cycles = 3;
      exp_job(a + 2, 3);
      step(1);
      bus.req_valid = 1'b0;
      check("busy_wait", bus.busy, 1'b1);
      step(1);
      check("enable_cycles_T", bus.gk_enable_cycles, 3);
      step(7);
      check("busy_done", bus.busy, 1'b1);
      step(1);
      check("busy_idle", bus.busy, 1'b0);
      check("enable_cycles_hold", bus.gk_enable_cycles, 3);

      // resource wait, 4 beats
      bus.in_fifo_level = 2;
      step(1);
      a = cyc;
      bus.req_valid = 1'b1;
      bus.req_cycles = 4;
      exp_job(a + 6, 4);
      step(1);
      bus.req_valid = 1'b0;
      step(4);
      check("busy_res_wait", bus.busy, 1'b1);
      bus.in_fifo_level = 4;
      step(12);

      // illegal request
      a = cyc;
      bus.req_valid = 1'b1;
      bus.req_cycles = 5;
      push(K_ERR, a + 1, 0);
      step(1);
      bus.req_valid = 1'b0;
      check("busy_illegal", bus.busy, 1'b0);
      step(1);
      check("busy_illegal2", bus.busy, 1'b0);
      step(2);

      // zero-beat request
      a = cyc;
      bus.req_valid = 1'b1;
      bus.req_cycles = 0;
      push(K_DONE, a + 1, 0);
      step(1);
      bus.req_valid = 1'b0;
      check("busy_zero", bus.busy, 1'b1);
      step(3);

      // abort in second RUN cycle
      a = cyc;
      bus.req_valid = 1'b1;
      bus.req_cycles = 3;
      push(K_START, a + 2, 3);
      push(K_SA, a + 3, 1);
      push(K_SA, a + 4, 3);
      push(K_SA, a + 5, 0);
      push(K_FLUSH, a + 5, 0);
      step(1);
      bus.req_valid = 1'b0;
      step(3);
      bus.abort = 1'b1;
      step(1);
      bus.abort = 1'b0;
      #1;
      check("ready_after_abort", bus.req_ready, 1'b1);
      check("busy_after_abort", bus.busy, 1'b0);
      check("sa_after_abort", bus.stage_active, 0);
      step(3);

      // back-to-back with request held through the first job
      a = cyc;
      bus.req_valid = 1'b1;
      bus.req_cycles = 2;
      exp_job(a + 2, 2);
      exp_job(a + 11, 2);
      step(8);
      check("ready_in_done", bus.req_ready, 1'b0);
      step(1);
      check("ready_after_done", bus.req_ready, 1'b1);
      step(1);
      bus.req_valid = 1'b0;
      step(10);

      // abort in IDLE blocks the request
      bus.req_valid = 1'b1;
      bus.req_cycles = 2;
      bus.abort = 1'b1;
      #1;
      check("ready_abort_idle", bus.req_ready, 1'b0);
      step(1);
      bus.req_valid = 1'b0;
      bus.abort = 1'b0;
      check("busy_abort_idle", bus.busy, 1'b0);
      step(3);
      check("busy_abort_idle2", bus.busy, 1'b0);

      // reset in the middle of a job
      a = cyc;
      bus.req_valid = 1'b1;
      bus.req_cycles = 3;
      push(K_START, a + 2, 3);
      push(K_SA, a + 3, 1);
      push(K_SA, a + 4, 0);
      step(1);
      bus.req_valid = 1'b0;
      step(2);
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      check("busy_mid_rst", bus.busy, 1'b0);
      check("enable_mid_rst", bus.gk_enable_cycles, 0);
      step(6);

      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL leftover: got %0d pending events, expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
